// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, parity modes and the
// ceil-log2 helper used by the receiver, transmitter and baud generator.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic PAR_MODE_EVEN = 1'b0;
    localparam logic PAR_MODE_ODD  = 1'b1;

    // Minimum one bit so a counter for a single value still has a legal width.
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs (RX data, CTS) with a
// configurable reset value so an idle-high line never looks active out of reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            meta <= RESET_VAL;
            o_q  <= RESET_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: synchronised input, false-start rejection, parity
// check and framing/break detection; results are qualified by one-cycle o_rxdone.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int NB_DATA      = 8,
    parameter int NB_OVS       = 16,
    parameter int NB_STOP_BITS = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rxdone,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_break
);

    localparam int CNT_W = clogb2(NB_OVS);
    localparam int IDX_W = clogb2(NB_DATA);
    localparam logic [CNT_W-1:0] CNT_HALF      = CNT_W'(NB_OVS / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(NB_OVS - 1);
    localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(NB_DATA - 1);
    localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(NB_STOP_BITS - 1);
    localparam logic             PAR_MODE      = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

    uart_state_t        state, state_nxt;
    logic               rx_s;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [NB_DATA-1:0] sr, sr_nxt;
    logic               par_err_q, par_err_nxt;
    logic               stop_err_q, stop_err_nxt;
    logic               ones_q, ones_nxt;
    logic               done_nxt;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    // The bit index is reused to count stop bits once the data bits are in.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        sr_nxt       = sr;
        par_err_nxt  = par_err_q;
        stop_err_nxt = stop_err_q;
        ones_nxt     = ones_q;
        done_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (cnt == CNT_HALF) begin
                        cnt_nxt = '0;
                        idx_nxt = '0;
                        if (rx_s) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt    = ST_DATA;
                            par_err_nxt  = 1'b0;
                            stop_err_nxt = 1'b0;
                            ones_nxt     = 1'b0;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (cnt == CNT_FULL) begin
                        cnt_nxt = '0;
                        sr_nxt  = {rx_s, sr[NB_DATA-1:1]};
                        if (idx == IDX_DATA_LAST) begin
                            idx_nxt   = '0;
                            state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (i_tick) begin
                    if (cnt == CNT_FULL) begin
                        cnt_nxt     = '0;
                        par_err_nxt = (^sr) ^ rx_s ^ PAR_MODE;
                        ones_nxt    = ones_q | rx_s;
                        state_nxt   = ST_STOP;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (i_tick) begin
                    if (cnt == CNT_FULL) begin
                        cnt_nxt      = '0;
                        stop_err_nxt = stop_err_q | ~rx_s;
                        ones_nxt     = ones_q | rx_s;
                        if (idx == IDX_STOP_LAST) begin
                            idx_nxt   = '0;
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Result registers only move on the strobe so they hold between frames.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            idx          <= '0;
            sr           <= '0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            ones_q       <= 1'b0;
            o_data       <= '0;
            o_rxdone     <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            sr         <= sr_nxt;
            par_err_q  <= par_err_nxt;
            stop_err_q <= stop_err_nxt;
            ones_q     <= ones_nxt;
            o_rxdone   <= done_nxt;
            if (done_nxt) begin
                o_data       <= sr_nxt;
                o_parity_err <= (PARITY_EN != 0) ? par_err_nxt : 1'b0;
                o_frame_err  <= stop_err_nxt;
                o_break      <= (sr_nxt == '0) && !ones_nxt;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: three configurations (8N1, 8E1, 7N2)
// driven from a vector table, random frames vs. a frame-level model, and corner sequences.
module tb_uart_rx_cfg;

    localparam int OVS      = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = OVS * TICK_DIV;

    logic       clk = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] tick_div = 2'd0;
    logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic       done_a, perr_a, ferr_a, brk_a;
    logic       done_b, perr_b, ferr_b, brk_b;
    logic       done_c, perr_c, ferr_c, brk_c;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         cnt [3];
    logic [8:0] cap_data [3];
    logic       cap_perr [3];
    logic       cap_ferr [3];
    logic       cap_brk  [3];
    int         cap_cyc  [3];

    int         base_cnt;
    int         start_cyc;
    logic [8:0] last_data [3];
    logic       last_perr [3];
    logic       last_ferr [3];
    logic       last_brk  [3];

    typedef struct {
        int         id;
        logic [8:0] data;
        logic       par;
        logic [1:0] stops;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    vec_t vecs [11];

    uart_rx_cfg dut_a (
        .clk(clk), .i_rst(rst_a), .i_tick(tick), .i_rx(rx_a),
        .o_data(data_a), .o_rxdone(done_a), .o_parity_err(perr_a),
        .o_frame_err(ferr_a), .o_break(brk_a)
    );

    uart_rx_cfg #(.PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .i_rst(rst_b), .i_tick(tick), .i_rx(rx_b),
        .o_data(data_b), .o_rxdone(done_b), .o_parity_err(perr_b),
        .o_frame_err(ferr_b), .o_break(brk_b)
    );

    uart_rx_cfg #(.NB_DATA(7), .NB_STOP_BITS(2)) dut_c (
        .clk(clk), .i_rst(rst_c), .i_tick(tick), .i_rx(rx_c),
        .o_data(data_c), .o_rxdone(done_c), .o_parity_err(perr_c),
        .o_frame_err(ferr_c), .o_break(brk_c)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_div = tick_div + 2'd1;
        tick     = (tick_div == 2'd0);
    end

    // Strobe monitor: every high o_rxdone sample is one reported frame.
    always @(negedge clk) begin
        cyc++;
        if (done_a === 1'b1) begin
            cnt[0]++; cap_data[0] = {1'b0, data_a}; cap_perr[0] = perr_a;
            cap_ferr[0] = ferr_a; cap_brk[0] = brk_a; cap_cyc[0] = cyc;
        end
        if (done_b === 1'b1) begin
            cnt[1]++; cap_data[1] = {1'b0, data_b}; cap_perr[1] = perr_b;
            cap_ferr[1] = ferr_b; cap_brk[1] = brk_b; cap_cyc[1] = cyc;
        end
        if (done_c === 1'b1) begin
            cnt[2]++; cap_data[2] = {2'b00, data_c}; cap_perr[2] = perr_c;
            cap_ferr[2] = ferr_c; cap_brk[2] = brk_c; cap_cyc[2] = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void cfgOf(input int id, output int nb, output logic pen, output int nst);
        nb  = (id == 2) ? 7 : 8;
        pen = (id == 1);
        nst = (id == 2) ? 2 : 1;
    endfunction

    // Frame-level reference: what the line carried, judged by the UART rules.
    function automatic void model(input int id, input logic [8:0] d, input logic p,
                                  input logic [1:0] s, output logic [8:0] ed,
                                  output logic pe, output logic fe, output logic bk);
        int nb, nst;
        logic pen, all_stops_low;
        cfgOf(id, nb, pen, nst);
        ed = d & 9'((1 << nb) - 1);
        pe = pen && ((^ed) ^ p);
        fe = (s[0] == 1'b0) || (nst == 2 && s[1] == 1'b0);
        all_stops_low = (s[0] == 1'b0) && (nst < 2 || s[1] == 1'b0);
        bk = (ed == 9'd0) && (!pen || !p) && all_stops_low;
    endfunction

    task automatic setRx(input int id, input logic b);
        case (id)
            0: rx_a = b;
            1: rx_b = b;
            default: rx_c = b;
        endcase
    endtask

    // Ends on the second negedge after a tick so every bit edge has the same tick phase.
    task automatic alignPhase();
        do @(posedge clk); while (tick !== 1'b1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic driveBit(input int id, input logic b);
        setRx(id, b);
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic applyStimulus(input int id, input logic [8:0] d, input logic p, input logic [1:0] s);
        int nb, nst;
        logic pen;
        cfgOf(id, nb, pen, nst);
        base_cnt = cnt[id];
        alignPhase();
        setRx(id, 1'b0);
        start_cyc = cyc;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < nb; i++) driveBit(id, d[i]);
        if (pen) driveBit(id, p);
        for (int i = 0; i < nst; i++) driveBit(id, s[i]);
        setRx(id, 1'b1);
        repeat (2 * BIT_CLK) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input int id, input logic [8:0] ed,
                               input logic pe, input logic fe, input logic bk);
        int nb, nst, lat, exp_lat;
        logic pen;
        cfgOf(id, nb, pen, nst);
        check({tag, " count"}, cnt[id] - base_cnt, 1);
        check({tag, " data"}, cap_data[id], ed);
        check({tag, " parity_err"}, cap_perr[id], pe);
        check({tag, " frame_err"}, cap_ferr[id], fe);
        check({tag, " break"}, cap_brk[id], bk);
        lat = cap_cyc[id] - start_cyc;
        exp_lat = (OVS / 2 + OVS * (nb + int'(pen) + nst)) * TICK_DIV;
        checks++;
        if (lat < exp_lat - TICK_DIV || lat > exp_lat + TICK_DIV + 6) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d clk expected %0d +/- one tick plus sync",
                     tag, lat, exp_lat);
        end
        last_data[id] = ed;
        last_perr[id] = pe;
        last_ferr[id] = fe;
        last_brk[id]  = bk;
    endtask

    initial begin
        logic [8:0] ed, rd;
        logic       pe, fe, bk, rp;
        logic [1:0] rs;
        int         id, base;

        for (int i = 0; i < 3; i++) cnt[i] = 0;

        vecs[0]  = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{0, 9'h03C, 1'b0, 2'b10, 9'h03C, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{0, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1, 9'h007, 1'b1, 2'b11, 9'h007, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1, 9'h007, 1'b0, 2'b11, 9'h007, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1, 9'h000, 1'b0, 2'b10, 9'h000, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{2, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{2, 9'h07F, 1'b0, 2'b01, 9'h07F, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{2, 9'h000, 1'b0, 2'b00, 9'h000, 1'b0, 1'b1, 1'b1};

        repeat (5) @(negedge clk);
        check("reset a data", {24'd0, data_a}, 0);
        check("reset b data", {24'd0, data_b}, 0);
        check("reset c data", {25'd0, data_c}, 0);
        check("reset flags a", {done_a, perr_a, ferr_a, brk_a}, 0);
        check("reset flags b", {done_b, perr_b, ferr_b, brk_b}, 0);
        check("reset flags c", {done_c, perr_c, ferr_c, brk_c}, 0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (2 * BIT_CLK) @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            applyStimulus(vecs[v].id, vecs[v].data, vecs[v].par, vecs[v].stops);
            checkOutput($sformatf("vec%0d", v), vecs[v].id, vecs[v].exp_data,
                        vecs[v].exp_perr, vecs[v].exp_ferr, vecs[v].exp_brk);
        end

        // Short low glitch on an idle line must be ignored entirely.
        base = cnt[0];
        alignPhase();
        setRx(0, 1'b0);
        repeat (3 * TICK_DIV) @(negedge clk);
        setRx(0, 1'b1);
        repeat (2 * BIT_CLK) @(negedge clk);
        check("glitch count", cnt[0] - base, 0);
        check("glitch data", {24'd0, data_a}, last_data[0]);
        check("glitch flags", {perr_a, ferr_a, brk_a},
              {last_perr[0], last_ferr[0], last_brk[0]});

        // Line held low for 20 bit times: each 9.5-bit window yields one break frame.
        base = cnt[0];
        alignPhase();
        setRx(0, 1'b0);
        repeat (20 * BIT_CLK) @(negedge clk);
        check("break count", cnt[0] - base, (2 * 20) / (1 + 2 * (8 + 1)));
        check("break data", cap_data[0], 0);
        check("break flag", cap_brk[0], 1);
        check("break frame_err", cap_ferr[0], 1);
        setRx(0, 1'b1);
        repeat (12 * BIT_CLK) @(negedge clk);

        for (int r = 0; r < 18; r++) begin
            id = r % 3;
            rd = 9'($urandom);
            rp = 1'($urandom);
            rs[0] = ($urandom_range(0, 3) != 0);
            rs[1] = ($urandom_range(0, 3) != 0);
            model(id, rd, rp, rs, ed, pe, fe, bk);
            applyStimulus(id, rd, rp, rs);
            checkOutput($sformatf("rand%0d", r), id, ed, pe, fe, bk);
        end

        // Reset in the middle of bit 3 discards the partial frame.
        base = cnt[2];
        alignPhase();
        setRx(2, 1'b0);
        repeat (BIT_CLK) @(negedge clk);
        driveBit(2, 1'b0);
        driveBit(2, 1'b1);
        driveBit(2, 1'b0);
        setRx(2, 1'b1);
        repeat (BIT_CLK / 2) @(negedge clk);
        rst_c = 1'b1;
        repeat (2) @(negedge clk);
        rst_c = 1'b0;
        check("midreset data", {25'd0, data_c}, 0);
        check("midreset flags", {done_c, perr_c, ferr_c, brk_c}, 0);
        repeat (3 * BIT_CLK) @(negedge clk);
        model(2, 9'h055, 1'b0, 2'b11, ed, pe, fe, bk);
        applyStimulus(2, 9'h055, 1'b0, 2'b11);
        checkOutput("after_reset", 2, ed, pe, fe, bk);
        check("midreset total strobes", cnt[2] - base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver: recovers one serial frame (start, NB_DATA data bits LSB first, optional parity, NB_STOP_BITS stop bits) from the asynchronous `i_rx` line, sampled by an oversampling tick from the shared baud-rate generator. It adds input synchronisation, false-start rejection, parity checking and framing/break detection to the basic receiver. It sits between the pad and the RX FIFO/interface logic; `o_data` is qualified by the single-cycle `o_rxdone` strobe.

## Interface
- `NB_DATA`, 8: data bits per frame, legal 5..9.
- `NB_OVS`, 16: `i_tick` pulses per bit period, even, >= 8.
- `NB_STOP_BITS`, 1: stop bits checked, 1 or 2.
- `PARITY_EN`, 0: 1 = parity bit present after data.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even; ignored when `PARITY_EN` = 0.
- `clk` in 1: single clock; all logic on rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_tick` in 1: one-`clk` oversampling strobe, NB_OVS per bit.
- `i_rx` in 1: asynchronous serial line, idle high.
- `o_data` out NB_DATA: last received word, LSB = first data bit.
- `o_rxdone` out 1: one-`clk` pulse, frame complete; `o_data` and flags valid.
- `o_parity_err` out 1: parity mismatch in last frame.
- `o_frame_err` out 1: some stop-bit sample was 0 in last frame.
- `o_break` out 1: last frame all-zero data, parity sample and stop samples.

## Operation
- `i_rx` passes through a 2-flop synchroniser (reset value 1); all FSM decisions use the synchronised bit `rx_s`.
- States: IDLE, START, DATA, PARITY, STOP. One-hot or binary encoding is an implementation choice; encoding constants come from the package.
- IDLE: tick counter cleared; `rx_s` = 0 -> START (no tick required).
- START: count ticks; on tick with counter = NB_OVS/2-1 sample `rx_s`: 0 -> DATA, counter and bit index cleared; 1 -> IDLE (glitch rejected, no strobe, flags unchanged).
- DATA: on tick with counter = NB_OVS-1, shift `rx_s` into MSB of shift register, clear counter, increment bit index; after bit index NB_DATA-1 -> PARITY if PARITY_EN else STOP.
- PARITY: sample at counter = NB_OVS-1; compute error = XOR(data bits, sample) XOR PARITY_ODD... precisely: error when XOR of data and parity bit is 1 for even, 0 for odd -> STOP.
- STOP: sample at counter = NB_OVS-1 per stop bit; any 0 sets frame error; after final stop sample -> IDLE and strobe.
- Counters: tick counter width clog2(NB_OVS); bit index width clog2(NB_DATA); no wrap beyond terminal values.
- Strobe cycle: `o_data`, `o_parity_err`, `o_frame_err`, `o_break` load together with `o_rxdone` = 1; held until next strobe. `o_parity_err` forced 0 when PARITY_EN = 0.
- Line held low after a break frame: FSM re-enters START immediately; each further all-zero frame strobes again with `o_break` = 1.
- `i_rst` mid-frame: FSM to IDLE, partial frame discarded, no strobe.

## Timing
- Reset values: `o_data` = 0, `o_rxdone` = 0, all error flags 0, state IDLE, synchroniser = 1.
- Input latency: 2 `clk` from `i_rx` edge to `rx_s`.
- Start falling edge to `o_rxdone`: (NB_OVS/2 + NB_OVS*(NB_DATA+PARITY_EN+NB_STOP_BITS)) ticks, plus sync latency, ±1 tick edge uncertainty.
- `o_rxdone` asserts the `clk` after the `i_tick` cycle that takes the final stop sample; high exactly one `clk`.
- Earliest next start detection: the `clk` after the strobe (mid last stop bit).

## Structure
- Package `uart_pkg`: FSM state constants, parity-mode constants, `clogb2` function shared with transmitter and baud generator.
- Sub-module `uart_sync2`: 2-flop synchroniser with reset value parameter; reused for CTS input.

## Test plan
- Default params, tick every 4 `clk`, send 0xA5 with 1 stop -> one `o_rxdone` pulse, `o_data` = 0xA5, all flags 0.
- PARITY_EN = 1, PARITY_ODD = 0, send 0x07 with parity bit 1 -> no error; with parity 0 -> `o_parity_err` = 1, `o_data` = 0x07.
- 0x3C with stop bit driven 0 -> `o_frame_err` = 1, `o_break` = 0; next clean frame 0x3C clears flag.
- Line low 20 bit times -> `o_rxdone` with `o_data` = 0, `o_break` = 1, `o_frame_err` = 1.
- 3-tick low glitch on idle line -> no `o_rxdone`, FSM back in IDLE, outputs unchanged.
- NB_DATA = 7, NB_STOP_BITS = 2, `i_rst` pulsed during bit 3 then frame 0x55 -> only one strobe, `o_data` = 0x55.
